// File: rtl/huffman_act_enc.sv
// Huffman encoder for one row of 4-bit activations.
// Serialises words 7..0 as variable-length codes, MSB first.
module huffman_act_enc #(
    parameter int num_words = 8,
    parameter int bw = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bw*num_words-1:0] in,
    input  logic                    valid_in,
    output logic                    ready,
    output logic                    out,
    output logic                    valid,
    input  logic                    ready_in
);

    localparam int wi_w = (num_words > 1) ? $clog2(num_words) : 1;
    localparam logic [wi_w-1:0] top_word = wi_w'(num_words - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [bw*num_words-1:0] blk;
    logic [bw*num_words-1:0] blk_nxt;
    logic [wi_w-1:0]         word_idx;
    logic [wi_w-1:0]         word_nxt;
    logic [3:0]              bit_idx;
    logic [3:0]              bit_nxt;

    logic [bw-1:0]           cur_word;
    logic [15:0]             cur_code;
    logic [3:0]              cur_len;
    logic [3:0]              bit_pos;
    logic                    last_bit;
    logic                    last_word;
    logic                    xfer;
    logic                    accept;

    assign cur_word  = blk[word_idx*bw +: bw];
    assign bit_pos   = cur_len - 4'd1 - bit_idx;
    assign last_bit  = (bit_idx == cur_len - 4'd1);
    assign last_word = (word_idx == '0);
    assign xfer      = (state == SHIFT) && ready_in;
    assign accept    = valid_in && ready;

    // Code table: right-aligned code word and its length
    always_comb begin
        cur_code = 16'b0;
        cur_len  = 4'd1;
        case (cur_word)
            4'd0:  begin cur_code = 16'b1;           cur_len = 4'd1;  end
            4'd1:  begin cur_code = 16'b0001;        cur_len = 4'd4;  end
            4'd2:  begin cur_code = 16'b0000;        cur_len = 4'd4;  end
            4'd3:  begin cur_code = 16'b0111;        cur_len = 4'd4;  end
            4'd4:  begin cur_code = 16'b0011;        cur_len = 4'd4;  end
            4'd5:  begin cur_code = 16'b0101;        cur_len = 4'd4;  end
            4'd6:  begin cur_code = 16'b0100;        cur_len = 4'd4;  end
            4'd7:  begin cur_code = 16'b0010;        cur_len = 4'd4;  end
            4'd8:  begin cur_code = 16'b01101;       cur_len = 4'd5;  end
            4'd9:  begin cur_code = 16'b011001;      cur_len = 4'd6;  end
            4'd10: begin cur_code = 16'b0110000;     cur_len = 4'd7;  end
            4'd11: begin cur_code = 16'b011000111;   cur_len = 4'd9;  end
            4'd12: begin cur_code = 16'b01100010;    cur_len = 4'd8;  end
            4'd13: begin cur_code = 16'b01100011011; cur_len = 4'd11; end
            4'd14: begin cur_code = 16'b01100011010; cur_len = 4'd11; end
            4'd15: begin cur_code = 16'b0110001100;  cur_len = 4'd10; end
            default: begin cur_code = 16'b0;         cur_len = 4'd1;  end
        endcase
    end

    // Handshake outputs; ready opens on the final bit of a block
    always_comb begin
        valid = (state == SHIFT);
        out   = valid && cur_code[bit_pos];
        ready = !reset &&
                ((state == IDLE) || (xfer && last_bit && last_word));
    end

    // Next-state and pointer/block update logic
    always_comb begin
        state_nxt = state;
        blk_nxt   = blk;
        word_nxt  = word_idx;
        bit_nxt   = bit_idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    blk_nxt   = in;
                    word_nxt  = top_word;
                    bit_nxt   = 4'd0;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (!last_bit) begin
                        bit_nxt = bit_idx + 4'd1;
                    end else if (!last_word) begin
                        word_nxt = word_idx - 1'b1;
                        bit_nxt  = 4'd0;
                    end else if (accept) begin
                        blk_nxt  = in;
                        word_nxt = top_word;
                        bit_nxt  = 4'd0;
                    end else begin
                        state_nxt = IDLE;
                        bit_nxt   = 4'd0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer and block registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            blk      <= '0;
            word_idx <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_nxt;
            blk      <= blk_nxt;
            word_idx <= word_nxt;
            bit_idx  <= bit_nxt;
        end
    end

endmodule

// File: tb/tb_huffman_act_enc.sv
// Self-checking bench for huffman_act_enc.
// Expected bitstreams come from a string code table.
module tb_huffman_act_enc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in = '0;
    logic        valid_in = 1'b0;
    logic        ready;
    logic        out;
    logic        valid;
    logic        ready_in = 1'b1;

    int checks = 0;
    int errors = 0;
    int rin_mode = 0;

    bit obs_q[$];
    bit exp_q[$];
    int rdy_q[$];

    string codes[16] = '{
        "1", "0001", "0000", "0111", "0011", "0101", "0100", "0010",
        "01101", "011001", "0110000", "011000111", "01100010",
        "01100011011", "01100011010", "0110001100"
    };

    huffman_act_enc #(
        .num_words(8),
        .bw(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .valid_in(valid_in),
        .ready(ready),
        .out(out),
        .valid(valid),
        .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    // Downstream acceptance pattern
    always @(posedge clk) begin
        #1;
        case (rin_mode)
            0: ready_in = 1'b1;
            1: ready_in = ~ready_in;
            default: ready_in = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Collect transferred bits and where ready opened
    always @(negedge clk) begin
        if (valid && ready_in) begin
            obs_q.push_back(out);
            if (ready) rdy_q.push_back(obs_q.size());
        end
    end

    function automatic void model_block(input logic [31:0] b);
        string s;
        for (int w = 7; w >= 0; w--) begin
            s = codes[b[4*w +: 4]];
            for (int c = 0; c < s.len(); c++)
                exp_q.push_back(s.getc(c) == "1");
        end
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic void clear_q();
        obs_q.delete();
        exp_q.delete();
        rdy_q.delete();
    endfunction

    task automatic send(input logic [31:0] b, output bit ok,
                        output bit lat_ok);
        int n;
        n = 0;
        ok = 0;
        @(posedge clk);
        #1;
        in = b;
        valid_in = 1'b1;
        while (n < 200 && !ok) begin
            @(negedge clk);
            if (ready) ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        valid_in = 1'b0;
        in = $urandom();
        @(negedge clk);
        lat_ok = valid;
    endtask

    task automatic wait_idle(input int lim, output bit timed_out);
        int n;
        n = 0;
        while (valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        timed_out = valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || valid !== 1'b0 || out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b out=%b want 0 0 0",
                     ready, valid, out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b want 1 0",
                     ready, valid);
        end
    endtask

    task automatic test_fixed();
        logic [31:0] vec [3];
        bit ok, lat, to;
        int d;
        vec[0] = 32'h00000000;
        vec[1] = 32'h01234567;
        vec[2] = 32'hDDDDDDDD;
        rin_mode = 0;
        for (int v = 0; v < 3; v++) begin
            clear_q();
            model_block(vec[v]);
            send(vec[v], ok, lat);
            checks++;
            if (!ok || !lat) begin
                errors++;
                $display("FAIL fixed_accept %h: acc=%b lat=%b want 1 1",
                         vec[v], ok, lat);
            end
            wait_idle(500, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL fixed_timeout %h: still valid", vec[v]);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL fixed_len %h: got %0d want %0d",
                         vec[v], obs_q.size(), exp_q.size());
            end
            d = first_diff();
            checks++;
            if (d >= 0) begin
                errors++;
                $display("FAIL fixed_bits %h: first diff at bit %0d",
                         vec[v], d);
            end
            checks++;
            if (rdy_q.size() != 1 || rdy_q[0] != exp_q.size()) begin
                errors++;
                $display("FAIL fixed_ready %h: %0d rises, at %0d want 1 at %0d",
                         vec[v], rdy_q.size(),
                         (rdy_q.size() > 0) ? rdy_q[0] : -1, exp_q.size());
            end
            checks++;
            if (ready !== 1'b1 || valid !== 1'b0) begin
                errors++;
                $display("FAIL fixed_idle %h: ready=%b valid=%b want 1 0",
                         vec[v], ready, valid);
            end
        end
    endtask

    task automatic test_stall();
        bit ok, lat;
        bit pv, po, pr;
        int holds, bad, n, d;
        clear_q();
        model_block(32'h0000000F);
        rin_mode = 1;
        send(32'h0000000F, ok, lat);
        pv = valid;
        po = out;
        pr = ready_in;
        holds = 0;
        bad = 0;
        n = 0;
        while (valid && n < 400) begin
            @(negedge clk);
            n++;
            if (pv && !pr) begin
                holds++;
                if (valid !== 1'b1 || out !== po) bad++;
            end
            pv = valid;
            po = out;
            pr = ready_in;
        end
        rin_mode = 0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_timeout: valid=%b want 0", valid);
        end
        checks++;
        if (bad != 0 || holds == 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad of %0d stalls want 0 of >0",
                     bad, holds);
        end
        d = first_diff();
        checks++;
        if (obs_q.size() != 17 || d >= 0) begin
            errors++;
            $display("FAIL stall_bits: len %0d diff %0d want 17 -1",
                     obs_q.size(), d);
        end
    endtask

    task automatic test_back_to_back();
        int acc, n, vcnt, gap, d;
        clear_q();
        model_block(32'h11111111);
        model_block(32'h00000000);
        rin_mode = 0;
        acc = 0;
        n = 0;
        vcnt = 0;
        gap = 0;
        @(posedge clk);
        #1;
        in = 32'h11111111;
        valid_in = 1'b1;
        while (acc < 2 && n < 300) begin
            @(negedge clk);
            n++;
            if (acc > 0) begin
                if (valid) vcnt++;
                else gap++;
            end
            if (ready) acc++;
            @(posedge clk);
            #1;
            if (acc == 1) in = 32'h00000000;
        end
        valid_in = 1'b0;
        in = $urandom();
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (!valid) break;
            vcnt++;
        end
        checks++;
        if (acc != 2 || gap != 0 || vcnt != 40) begin
            errors++;
            $display("FAIL b2b_stream: acc=%0d gaps=%0d valid=%0d want 2 0 40",
                     acc, gap, vcnt);
        end
        d = first_diff();
        checks++;
        if (obs_q.size() != 40 || d >= 0) begin
            errors++;
            $display("FAIL b2b_bits: len %0d diff %0d want 40 -1",
                     obs_q.size(), d);
        end
        checks++;
        if (rdy_q.size() != 2 || rdy_q[0] != 32 || rdy_q[1] != 40) begin
            errors++;
            $display("FAIL b2b_ready: %0d rises first %0d want 2 at 32,40",
                     rdy_q.size(), (rdy_q.size() > 0) ? rdy_q[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, lat, to;
        int d;
        clear_q();
        model_block(32'h88888888);
        exp_q = exp_q[0:4];
        rin_mode = 0;
        send(32'h88888888, ok, lat);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: ready=%b want 0", ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid: valid=%b out=%b want 0 0",
                     valid, out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: ready=%b valid=%b want 1 0",
                     ready, valid);
        end
        d = first_diff();
        checks++;
        if (obs_q.size() != 5 || d >= 0) begin
            errors++;
            $display("FAIL mid_bits: len %0d diff %0d want 5 -1",
                     obs_q.size(), d);
        end
        clear_q();
        model_block(32'h00000000);
        send(32'h00000000, ok, lat);
        wait_idle(100, to);
        d = first_diff();
        checks++;
        if (!ok || to || obs_q.size() != 8 || d >= 0) begin
            errors++;
            $display("FAIL mid_next: acc=%b to=%b len %0d diff %0d want 1 0 8 -1",
                     ok, to, obs_q.size(), d);
        end
    endtask

    task automatic test_random();
        logic [31:0] b;
        bit ok, lat, to;
        int d;
        rin_mode = 2;
        for (int t = 0; t < 24; t++) begin
            b = $urandom();
            clear_q();
            model_block(b);
            send(b, ok, lat);
            wait_idle(2000, to);
            d = first_diff();
            checks++;
            if (!ok || !lat || to || obs_q.size() != exp_q.size() || d >= 0)
            begin
                errors++;
                $display("FAIL rand %h: acc=%b lat=%b to=%b len %0d/%0d diff %0d",
                         b, ok, lat, to, obs_q.size(), exp_q.size(), d);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rin_mode = 0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
